// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD line writer: FSM encoding,
// default set-address commands and Avalon register addresses.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    FIN  = 2'd3
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_LINE0 = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1 = 8'hC0;
  localparam logic       ADDR_CMD      = 1'b0;
  localparam logic       ADDR_DATA     = 1'b1;
  localparam logic [7:0] LCD_SPACE     = 8'h20;

  // Index width for a buffer of the given depth, never narrower than one bit.
  function automatic int idx_width(input int chars);
    return (chars > 1) ? $clog2(chars) : 1;
  endfunction

endpackage

// File: rtl/lcd_line_buffer.sv
// Line buffer: synchronous write port, asynchronous read port; reset fills
// every entry with a space so an unwritten line shows blank.
module lcd_line_buffer
  import lcd_pkg::*;
#(
  parameter int CHARS = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [3:0]       waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [CHARS];
  logic       waddr_ok;

  assign waddr_ok = (int'(waddr_i) < CHARS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHARS; i++) begin
        mem_q[i] <= LCD_SPACE;
      end
    end else if (we_i && waddr_ok) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lcd_line_writer.sv
// Pushes one buffered LCD line over Avalon-MM: a set-address command for the
// selected line followed by CHARS data writes, then a one-cycle done pulse.
module lcd_line_writer
  import lcd_pkg::*;
#(
  parameter int         CHARS     = 16,
  parameter logic [7:0] CMD_LINE0 = LCD_CMD_LINE0,
  parameter logic [7:0] CMD_LINE1 = LCD_CMD_LINE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       char_we,
  input  logic [3:0] char_addr,
  input  logic [7:0] char_data,
  input  logic       start,
  input  logic       line_sel,
  output logic       busy,
  output logic       done,
  output logic       address,
  output logic       chipselect,
  output logic       write,
  output logic [7:0] writedata,
  input  logic       waitrequest
);

  localparam int               IDX_W    = idx_width(CHARS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS - 1);

  lcd_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             line_q, line_d;
  logic [7:0]       buf_rdata;
  logic             buf_we;

  // Buffer is frozen while a request is being transferred.
  assign buf_we = char_we & ~busy;

  lcd_line_buffer #(
    .CHARS (CHARS),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (buf_we),
    .waddr_i (char_addr),
    .wdata_i (char_data),
    .raddr_i (idx_q),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      line_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
    end
  end

  // Avalon outputs depend only on registered state, so they hold across stalls.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    line_d     = line_q;
    busy       = 1'b0;
    done       = 1'b0;
    address    = ADDR_CMD;
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          line_d  = line_sel;
          idx_d   = '0;
          state_d = CMD;
        end
      end
      CMD: begin
        busy       = 1'b1;
        address    = ADDR_CMD;
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = line_q ? CMD_LINE1 : CMD_LINE0;
        if (!waitrequest) begin
          state_d = DATA;
        end
      end
      DATA: begin
        busy       = 1'b1;
        address    = ADDR_DATA;
        chipselect = 1'b1;
        write      = 1'b1;
        writedata  = buf_rdata;
        if (!waitrequest) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_line_writer.sv
// Directed bench for lcd_line_writer: reset state, line pushes with and
// without stalls, busy-time lockout, reset abort and same-cycle write+start.
module tb_lcd_line_writer;

  logic       clk = 1'b0;
  logic       reset, char_we, start, line_sel, waitrequest;
  logic [3:0] char_addr;
  logic [7:0] char_data;
  logic       busy, done, address, chipselect, write;
  logic [7:0] writedata;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_buf [16];

  int         cap_n, first_wr_cycle, done_cnt, done_cycle, busy_at_done;
  int         cs_at_done, unstable, post_writes;
  bit         timed_out;
  logic       cap_addr [32];
  logic [7:0] cap_data [32];
  int         inj_cycle = -1;

  always #5 clk = ~clk;

  lcd_line_writer dut (
    .clk         (clk),
    .reset       (reset),
    .char_we     (char_we),
    .char_addr   (char_addr),
    .char_data   (char_data),
    .start       (start),
    .line_sel    (line_sel),
    .busy        (busy),
    .done        (done),
    .address     (address),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [3:0] a, input logic [7:0] d);
    char_we = 1'b1; char_addr = a; char_data = d;
    tick();
    char_we = 1'b0;
  endtask

  task automatic launch(input logic ls);
    start = 1'b1; line_sel = ls;
    tick();
    start = 1'b0;
  endtask

  // Drives waitrequest and records every completed transfer, starting in the
  // first cycle after the start edge (cycle 1).
  task automatic capture(input int stall, input int budget);
    int         sc;
    int         extra;
    bit         seen_done;
    logic [10:0] snap;
    cap_n = 0; first_wr_cycle = -1; done_cnt = 0; done_cycle = -1;
    busy_at_done = 0; cs_at_done = 0; unstable = 0; post_writes = 0;
    sc = 0; extra = 0; seen_done = 0; snap = '0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      start = 1'b0; char_we = 1'b0;
      if (cyc == inj_cycle) begin
        start = 1'b1; line_sel = 1'b1;
        char_we = 1'b1; char_addr = 4'd3; char_data = 8'h5A;
      end
      if (write === 1'b1) begin
        if (first_wr_cycle < 0) first_wr_cycle = cyc;
        if (seen_done) post_writes++;
        if (sc > 0 && snap !== {address, chipselect, write, writedata}) unstable++;
        if (sc < stall) begin
          if (sc == 0) snap = {address, chipselect, write, writedata};
          waitrequest = 1'b1;
          sc++;
        end else begin
          waitrequest = 1'b0;
          sc = 0;
          if (cap_n < 32) begin
            cap_addr[cap_n] = address;
            cap_data[cap_n] = writedata;
          end
          cap_n++;
        end
      end else begin
        waitrequest = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cycle = cyc;
        if (busy !== 1'b0) busy_at_done++;
        if (chipselect !== 1'b0) cs_at_done++;
        seen_done = 1'b1;
      end
      if (seen_done) extra++;
      tick();
      if (extra >= 4) break;
    end
    start = 1'b0; char_we = 1'b0; waitrequest = 1'b0;
    timed_out = !seen_done;
  endtask

  task automatic test_reset();
    reset = 1'b1; char_we = 1'b0; char_addr = '0; char_data = '0;
    start = 1'b0; line_sel = 1'b0; waitrequest = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, chipselect, write, address} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000", {busy, done, chipselect, write, address});
    end
    checks++;
    if (writedata !== 8'h00) begin
      errors++;
      $display("FAIL reset_writedata: got %h required 00", writedata);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'h20;
    tick();
    checks++;
    if ({busy, done, chipselect, write} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b required 0000", {busy, done, chipselect, write});
    end
  endtask

  task automatic test_hello();
    logic [7:0] s [5];
    s[0] = 8'h48; s[1] = 8'h45; s[2] = 8'h4C; s[3] = 8'h4C; s[4] = 8'h4F;
    for (int i = 0; i < 5; i++) begin
      write_char(4'(i), s[i]);
      exp_buf[i] = s[i];
    end
    launch(1'b0);
    capture(0, 60);
    checks++;
    if (timed_out || cap_n != 17) begin
      errors++;
      $display("FAIL hello_count: got %0d transfers (timeout=%0d) required 17", cap_n, timed_out);
    end
    checks++;
    if (first_wr_cycle != 1) begin
      errors++;
      $display("FAIL hello_first_cycle: got %0d required 1", first_wr_cycle);
    end
    checks++;
    if (cap_addr[0] !== 1'b0 || cap_data[0] !== 8'h80) begin
      errors++;
      $display("FAIL hello_cmd: got (%b,%h) required (0,80)", cap_addr[0], cap_data[0]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_addr[i+1] !== 1'b1 || cap_data[i+1] !== exp_buf[i]) begin
        errors++;
        $display("FAIL hello_data[%0d]: got (%b,%h) required (1,%h)", i, cap_addr[i+1], cap_data[i+1], exp_buf[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cycle != 18) begin
      errors++;
      $display("FAIL hello_done: got %0d pulses at cycle %0d required 1 at 18", done_cnt, done_cycle);
    end
    checks++;
    if (busy_at_done != 0 || cs_at_done != 0 || post_writes != 0) begin
      errors++;
      $display("FAIL hello_fin: busy=%0d cs=%0d post=%0d required 0/0/0", busy_at_done, cs_at_done, post_writes);
    end
  endtask

  task automatic test_stall_line1();
    launch(1'b1);
    capture(5, 200);
    checks++;
    if (timed_out || cap_n != 17) begin
      errors++;
      $display("FAIL stall_count: got %0d transfers (timeout=%0d) required 17", cap_n, timed_out);
    end
    checks++;
    if (cap_addr[0] !== 1'b0 || cap_data[0] !== 8'hC0) begin
      errors++;
      $display("FAIL stall_cmd: got (%b,%h) required (0,C0)", cap_addr[0], cap_data[0]);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_addr[i+1] !== 1'b1 || cap_data[i+1] !== exp_buf[i]) begin
        errors++;
        $display("FAIL stall_data[%0d]: got (%b,%h) required (1,%h)", i, cap_addr[i+1], cap_data[i+1], exp_buf[i]);
      end
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL stall_stable: got %0d changes while stalled required 0", unstable);
    end
    checks++;
    if (done_cnt != 1 || done_cycle != 103) begin
      errors++;
      $display("FAIL stall_done: got %0d pulses at cycle %0d required 1 at 103", done_cnt, done_cycle);
    end
  endtask

  task automatic test_busy_ignore();
    inj_cycle = 10;
    launch(1'b0);
    capture(0, 60);
    inj_cycle = -1;
    checks++;
    if (cap_n != 17 || done_cnt != 1 || post_writes != 0) begin
      errors++;
      $display("FAIL busy_restart: got n=%0d done=%0d post=%0d required 17/1/0", cap_n, done_cnt, post_writes);
    end
    launch(1'b0);
    capture(0, 60);
    checks++;
    if (cap_data[4] !== exp_buf[3]) begin
      errors++;
      $display("FAIL busy_write_dropped: got buffer[3]=%h required %h", cap_data[4], exp_buf[3]);
    end
    checks++;
    if (cap_data[0] !== 8'h80 || cap_n != 17) begin
      errors++;
      $display("FAIL busy_next_req: got cmd %h n=%0d required 80 and 17", cap_data[0], cap_n);
    end
  endtask

  task automatic test_reset_abort();
    int dn;
    write_char(4'd7, 8'h37);
    exp_buf[7] = 8'h37;
    launch(1'b0);
    waitrequest = 1'b0;
    for (int c = 1; c < 9; c++) tick();
    waitrequest = 1'b1;
    checks++;
    if (address !== 1'b1 || writedata !== 8'h37) begin
      errors++;
      $display("FAIL abort_idx7: got (%b,%h) required (1,37)", address, writedata);
    end
    tick();
    checks++;
    if (write !== 1'b1 || writedata !== 8'h37) begin
      errors++;
      $display("FAIL abort_hold: got write=%b data=%h required 1,37", write, writedata);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; waitrequest = 1'b0;
    for (int i = 0; i < 16; i++) exp_buf[i] = 8'h20;
    checks++;
    if ({chipselect, write, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL abort_state: got cs/wr/busy/done=%b required 0000", {chipselect, write, busy, done});
    end
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    checks++;
    if (dn != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses required 0", dn);
    end
    launch(1'b0);
    capture(0, 60);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (cap_data[i+1] !== 8'h20) begin
        errors++;
        $display("FAIL abort_buf[%0d]: got %h required 20", i, cap_data[i+1]);
      end
    end
  endtask

  task automatic test_same_cycle();
    char_we = 1'b1; char_addr = 4'd15; char_data = 8'h21;
    start = 1'b1; line_sel = 1'b0;
    tick();
    char_we = 1'b0; start = 1'b0;
    exp_buf[15] = 8'h21;
    capture(0, 60);
    checks++;
    if (cap_n != 17 || cap_addr[0] !== 1'b0 || cap_data[0] !== 8'h80) begin
      errors++;
      $display("FAIL same_cmd: got n=%0d (%b,%h) required 17 (0,80)", cap_n, cap_addr[0], cap_data[0]);
    end
    checks++;
    if (cap_addr[16] !== 1'b1 || cap_data[16] !== 8'h21) begin
      errors++;
      $display("FAIL same_last: got (%b,%h) required (1,21)", cap_addr[16], cap_data[16]);
    end
    checks++;
    if (cap_data[15] !== 8'h20 || done_cycle != 18) begin
      errors++;
      $display("FAIL same_rest: got data14=%h done@%0d required 20 and 18", cap_data[15], done_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_stall_line1();
    test_busy_ignore();
    test_reset_abort();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
